// File: rtl/debounce_array.sv
// Multi-channel button debouncer: per-channel 2-flop sync, symmetric filter, edge pulses.
// Optional long-press detector built when DEBOUNCE_LONG_PRESS_EN is defined.

module debounce_lane #(
  parameter int STABLE_CYCLES = 100000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic           IDLE     = (ACTIVE_LOW != 0);

  logic          s0, s1, act;
  logic [CW-1:0] cnt;

  assign act = s1 ^ IDLE;

  // Any sample agreeing with the current level throws away the accumulated run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0    <= IDLE;
      s1    <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s0    <= btn;
      s1    <= s0;
      press <= 1'b0;
      rel   <= 1'b0;
      if (act == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= act;
        cnt   <= '0;
        press <= act;
        rel   <= ~act;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int            HW    = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hcnt;

  // Uses the pre-edge level, so a release on the terminal edge still fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      long_p <= 1'b0;
    end else begin
      long_p <= level && (hcnt == HLAST);
      if (!level)
        hcnt <= '0;
      else if (hcnt != HMAX)
        hcnt <= hcnt + 1'b1;
    end
  end
`else
  assign long_p = 1'b0;
`endif

endmodule

module debounce_array #(
  parameter int N_CH          = 5,
  parameter int STABLE_CYCLES = 100000,
  parameter int LONG_CYCLES   = 50000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o
);

  debounce_lane #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .LONG_CYCLES  (LONG_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_lane [N_CH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .level (level_o),
    .press (press_o),
    .rel   (release_o),
    .long_p(long_o)
  );

endmodule
